// File: rtl/axi_cdc_chan_src.sv
// axi_cdc_chan_src
// Write half of a gray-pointer clock-domain-crossing FIFO for one AXI channel.
// Everything here runs on src_clk_i. The storage array and the gray write
// pointer are exported without synchronisation; the destination half takes
// care of them. The gray read pointer coming back is synchronised here and
// used to decide full, and to decide when an isolate request has drained.

module axi_cdc_chan_src #(
   parameter int DataWidth  = 1,
   parameter int LogDepth   = 1,
   parameter int SyncStages = 2
) (
   input  logic                              src_clk_i,
   input  logic                              src_rst_ni,
   input  logic [DataWidth-1:0]              src_data_i,
   input  logic                              src_valid_i,
   output logic                              src_ready_o,
   input  logic                              isolate_i,
   output logic                              isolated_o,
   output logic [(2**LogDepth)*DataWidth-1:0] async_data_o,
   output logic [LogDepth:0]                 async_wptr_o,
   input  logic [LogDepth:0]                 async_rptr_i
);

   localparam int Depth = 2**LogDepth;

   // In gray code, "one full lap ahead" means the top two bits differ and
   // the remaining bits match.
   localparam logic [LogDepth:0] FullMask = (LogDepth+1)'(3) << (LogDepth-1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [DataWidth-1:0] mem_q [Depth];
   logic [LogDepth:0]    wptr_bin_q;
   logic [LogDepth:0]    wptr_bin_next;
   logic [LogDepth:0]    wptr_gray_q;
   logic [LogDepth:0]    sync_q [SyncStages];
   logic [LogDepth:0]    rptr_sync;
   logic                 full;
   logic                 empty_far;
   logic                 push;

   assign rptr_sync     = sync_q[SyncStages-1];
   assign full          = (wptr_gray_q == (rptr_sync ^ FullMask));
   assign empty_far     = (wptr_gray_q == rptr_sync);
   assign push          = src_valid_i & src_ready_o;
   assign wptr_bin_next = wptr_bin_q + (LogDepth+1)'(1);
   assign async_wptr_o  = wptr_gray_q;

   // Flatten the storage array onto the export bus, entry i at slot i.
   for (genvar g = 0; g < Depth; g++) begin : g_data_out
      assign async_data_o[g*DataWidth +: DataWidth] = mem_q[g];
   end

   // Store an accepted beat and advance both pointer forms on the same edge,
   // so the far side never sees a pointer ahead of its data.
   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wptr_bin_q  <= '0;
         wptr_gray_q <= '0;
      end else if (push) begin
         mem_q[wptr_bin_q[LogDepth-1:0]] <= src_data_i;
         wptr_bin_q  <= wptr_bin_next;
         wptr_gray_q <= wptr_bin_next ^ (wptr_bin_next >> 1);
      end
   end

   // Bring the far-side gray read pointer into this clock domain.
   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         for (int i = 0; i < SyncStages; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= async_rptr_i;
         for (int i = 1; i < SyncStages; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Isolate/drain state register.
   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; dropping isolate_i always returns to
   // RUN, even when the drain would have completed in the same cycle.
   always_comb begin
      state_d     = state_q;
      src_ready_o = 1'b0;
      isolated_o  = 1'b0;
      case (state_q)
         RUN: begin
            if (isolate_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!isolate_i) begin
               state_d = RUN;
            end else if (empty_far) begin
               state_d = ISOLATED;
            end
         end
         ISOLATED: begin
            if (!isolate_i) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
      src_ready_o = ~full & (state_q == RUN) & ~isolate_i;
      isolated_o  = (state_q == ISOLATED);
   end

endmodule

// File: tb/tb_axi_cdc_chan_src.sv
// tb_axi_cdc_chan_src
// Directed vectors for reset, fill, release-from-full, isolate and abort,
// followed by random traffic compared against a count-based FIFO model.

module tb_axi_cdc_chan_src;

   localparam int DW    = 8;
   localparam int LD    = 2;
   localparam int SS    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] data;
   logic          valid;
   logic          ready;
   logic          isolate;
   logic          iso_out;
   logic [31:0]   adata;
   logic [LD:0]   wptr;
   logic [LD:0]   rptr;

   int n_checks = 0;
   int n_pass   = 0;

   // Free-running source clock.
   always #5 clk = ~clk;

   axi_cdc_chan_src #(
      .DataWidth (DW),
      .LogDepth  (LD),
      .SyncStages(SS)
   ) dut (
      .src_clk_i   (clk),
      .src_rst_ni  (rst_n),
      .src_data_i  (data),
      .src_valid_i (valid),
      .src_ready_o (ready),
      .isolate_i   (isolate),
      .isolated_o  (iso_out),
      .async_data_o(adata),
      .async_wptr_o(wptr),
      .async_rptr_i(rptr)
   );

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic [LD:0]   rp;
      logic          exp_ready;
      logic [LD:0]   exp_wptr;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [LD:0] gray(input int x);
      logic [LD:0] b;
      b = (LD+1)'(x);
      return b ^ (b >> 1);
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic iso, input logic [LD:0] rp);
      valid   = v;
      data    = d;
      isolate = iso;
      rptr    = rp;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'd0);
      step();
      step();
      check_output("rst_ready", 32'(ready), 32'd1);
      check_output("rst_wptr", 32'(wptr), 32'd0);
      check_output("rst_isolated", 32'(iso_out), 32'd0);
      check_output("rst_data", adata, 32'd0);
      apply_stimulus(1'b0, 8'h00, 1'b1, 3'd0);
      check_output("rst_ready_iso", 32'(ready), 32'd0);
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'd0);
      rst_n = 1'b1;
      step();
   endtask

   // Reference model state for the random phase.
   int            wcount;
   int            rcount;
   int            hist[$];
   logic [DW-1:0] mmem[DEPTH];
   bit            closing;
   bit            isolated_m;

   initial begin
      rst_n   = 1'b0;
      valid   = 1'b0;
      data    = '0;
      isolate = 1'b0;
      rptr    = '0;

      // Reset, then a single push of 0xA5.
      do_reset();
      apply_stimulus(1'b1, 8'hA5, 1'b0, 3'd0);
      check_output("a5_ready", 32'(ready), 32'd1);
      step();
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'd0);
      check_output("a5_wptr", 32'(wptr), 32'd1);
      check_output("a5_entry0", 32'(adata[7:0]), 32'hA5);

      // Fill to capacity, hold off the fifth beat, then release with one pop.
      vecs[0] = '{1'b1, 8'h10, 3'd0, 1'b1, 3'd1};
      vecs[1] = '{1'b1, 8'h11, 3'd0, 1'b1, 3'd3};
      vecs[2] = '{1'b1, 8'h12, 3'd0, 1'b1, 3'd2};
      vecs[3] = '{1'b1, 8'h13, 3'd0, 1'b1, 3'd6};
      vecs[4] = '{1'b1, 8'h14, 3'd0, 1'b0, 3'd6};
      vecs[5] = '{1'b1, 8'h14, 3'd1, 1'b0, 3'd6};
      vecs[6] = '{1'b1, 8'h14, 3'd1, 1'b0, 3'd6};
      vecs[7] = '{1'b1, 8'h14, 3'd1, 1'b1, 3'd7};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].v, vecs[i].d, 1'b0, vecs[i].rp);
         check_output($sformatf("fill_ready[%0d]", i), 32'(ready), 32'(vecs[i].exp_ready));
         step();
         check_output($sformatf("fill_wptr[%0d]", i), 32'(wptr), 32'(vecs[i].exp_wptr));
      end
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'd1);
      check_output("fill_entries", adata, 32'h13121114);

      // Isolate with three beats outstanding, drain, then reopen.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 8'(8'h21 + i), 1'b0, 3'd0);
         step();
      end
      check_output("iso_wptr3", 32'(wptr), 32'd2);
      apply_stimulus(1'b1, 8'h24, 1'b1, 3'd0);
      check_output("iso_ready_edge", 32'(ready), 32'd0);
      step();
      check_output("iso_not_accepted", 32'(wptr), 32'd2);
      check_output("iso_drain_low", 32'(iso_out), 32'd0);
      apply_stimulus(1'b0, 8'h00, 1'b1, 3'd2);
      step();
      check_output("iso_edge1", 32'(iso_out), 32'd0);
      step();
      check_output("iso_edge2", 32'(iso_out), 32'd0);
      step();
      check_output("iso_edge3", 32'(iso_out), 32'd1);
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'd2);
      check_output("iso_ready_closed", 32'(ready), 32'd0);
      step();
      check_output("iso_release_iso", 32'(iso_out), 32'd0);
      check_output("iso_release_ready", 32'(ready), 32'd1);

      // Abort a drain in the same cycle the FIFO becomes empty.
      do_reset();
      apply_stimulus(1'b1, 8'h31, 1'b0, 3'd0);
      step();
      apply_stimulus(1'b0, 8'h00, 1'b1, 3'd0);
      step();
      apply_stimulus(1'b0, 8'h00, 1'b1, 3'd1);
      step();
      check_output("abort_edge1", 32'(iso_out), 32'd0);
      step();
      check_output("abort_edge2", 32'(iso_out), 32'd0);
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'd1);
      step();
      check_output("abort_iso", 32'(iso_out), 32'd0);
      check_output("abort_ready", 32'(ready), 32'd1);
      step();
      check_output("abort_iso_later", 32'(iso_out), 32'd0);

      // Random traffic against a count-based model of the FIFO.
      do_reset();
      wcount     = 0;
      rcount     = 0;
      closing    = 1'b0;
      isolated_m = 1'b0;
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(0);
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      begin
         logic          r_iso;
         logic          r_v;
         logic [DW-1:0] r_d;
         logic          exp_ready;
         int            occ;
         r_iso = 1'b0;
         for (int c = 0; c < 600; c++) begin
            r_v = ($urandom_range(0, 3) != 0);
            r_d = DW'($urandom);
            if ($urandom_range(0, 24) == 0) r_iso = ~r_iso;
            if (rcount < wcount && $urandom_range(0, 2) == 0) rcount++;
            apply_stimulus(r_v, r_d, r_iso, gray(rcount));
            occ       = wcount - hist[0];
            exp_ready = (occ != DEPTH) && !closing && !r_iso;
            check_output($sformatf("rnd_ready[%0d]", c), 32'(ready), 32'(exp_ready));
            step();
            if (r_v && exp_ready) begin
               mmem[wcount % DEPTH] = r_d;
               wcount++;
            end
            hist.push_back(rcount);
            void'(hist.pop_front());
            if (!r_iso) begin
               closing    = 1'b0;
               isolated_m = 1'b0;
            end else if (!closing) begin
               closing = 1'b1;
            end else if (occ == 0) begin
               isolated_m = 1'b1;
            end
            check_output($sformatf("rnd_wptr[%0d]", c), 32'(wptr), 32'(gray(wcount)));
            check_output($sformatf("rnd_iso[%0d]", c), 32'(iso_out), 32'(isolated_m));
            check_output($sformatf("rnd_data[%0d]", c), adata, {mmem[3], mmem[2], mmem[1], mmem[0]});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_cdc_chan_src.md
# axi_cdc_chan_src

Source (write) half of a single-channel gray-pointer clock-domain-crossing FIFO for AXI channels, running entirely in the source clock domain. It accepts beats via valid/ready, stores them in a register array exported unsynchronised to the destination half, publishes a gray-coded write pointer, and synchronises the returned gray read pointer to detect full. An isolate/drain state machine stops accepting beats on request and acknowledges only once every stored beat has been consumed by the far side. It is the push-side counterpart of the destination-side pop FIFOs, instantiated once per AXI channel (AW, W, AR in the master domain; B, R in the slave domain).

## Interface
- DataWidth, default 1: bits per beat (packed AXI channel struct width).
- LogDepth, default 1: FIFO depth is 2**LogDepth entries; legal range 1..8.
- SyncStages, default 2: flip-flop stages on the read-pointer synchroniser; legal range 2..4.

- src_clk_i  in  1  source clock; the block's only clock.
- src_rst_ni  in  1  asynchronous, active-low reset.
- src_data_i  in  DataWidth  beat payload.
- src_valid_i  in  1  beat valid.
- src_ready_o  out  1  beat ready.
- isolate_i  in  1  request to stop accepting and drain.
- isolated_o  out  1  drain complete; FIFO empty and closed.
- async_data_o  out  2**LogDepth*DataWidth  storage array; entry i occupies bits [i*DataWidth +: DataWidth].
- async_wptr_o  out  LogDepth+1  gray-coded write pointer, registered.
- async_rptr_i  in  LogDepth+1  gray-coded read pointer from the destination domain, asynchronous.

## Operation
- Binary write pointer wptr_bin (LogDepth+1 bits) wraps modulo 2**(LogDepth+1). async_wptr_o is a register holding wptr_bin ^ (wptr_bin >> 1); exactly one bit changes per push.
- Push (src_valid_i & src_ready_o at a rising edge): entry wptr_bin[LogDepth-1:0] <= src_data_i, and wptr_bin and async_wptr_o advance. Data and pointer update on the same edge.
- rptr_sync is async_rptr_i through SyncStages flops; it is compared in gray, with no conversion.
- full = (async_wptr_o == rptr_sync ^ {2'b11, (LogDepth-1)'b0}), i.e. the top two bits are inverted and the rest are equal.
- empty_far = (async_wptr_o == rptr_sync).
- src_ready_o = ~full & (state == RUN) & ~isolate_i. This is combinational, so a beat presented in the cycle isolate_i rises is not accepted.
- State machine (2 bits):
  - RUN: isolate_i=1 -> DRAIN.
  - DRAIN: isolate_i=0 -> RUN; else empty_far -> ISOLATED.
  - ISOLATED: isolate_i=0 -> RUN.
- isolated_o = (state == ISOLATED), registered through the state.
- Valid/ready protocol: once src_ready_o is low, the upstream must hold valid and data stable. The block never retracts ready within a cycle except through isolate_i.

## Timing
- Reset values: wptr_bin=0, async_wptr_o=0, every async_data_o entry=0, all sync flops=0, state=RUN, isolated_o=0. While in reset, src_ready_o = ~isolate_i.
- Push-to-pointer latency: async_wptr_o changes 1 cycle after the accepting edge.
- Read-pointer latency: a change on async_rptr_i reaches full/empty_far after SyncStages src_clk_i edges. src_ready_o can therefore rise SyncStages cycles after the far side pops.
- Capacity is exactly 2**LogDepth beats. After that many pushes with no pops, src_ready_o=0 until rptr_sync advances.
- Throughput is 1 beat/cycle while not full.
- Drain: isolated_o rises 1 cycle after empty_far is seen in DRAIN. If isolate_i is asserted while the FIFO is already empty, isolated_o rises 2 cycles after the isolate_i edge (RUN->DRAIN->ISOLATED).
- Simultaneous isolate_i deassertion and empty_far in DRAIN: RUN wins.
- Reset mid-operation clears pointers immediately. The destination half must be reset in the same window; the block does not detect a one-sided reset.

## Test plan
- Reset: hold src_rst_ni=0 with isolate_i=0 -> src_ready_o=1, async_wptr_o=0, isolated_o=0, all data=0. Release it, then push 0xA5 with DataWidth=8 -> entry0=0xA5 and async_wptr_o=1 one cycle later.
- Fill (LogDepth=2, SyncStages=2, async_rptr_i held at 0): 4 back-to-back pushes -> async_wptr_o sequence 1,3,2,6, src_ready_o=0 after the 4th, and a 5th valid is held off.
- Release from full: set async_rptr_i=1 -> src_ready_o=1 exactly 2 edges later, and the 5th beat lands in entry0.
- Wrap-around: 8 pushes and 8 pops (async_rptr_i following the gray sequence) -> async_wptr_o returns to 0, entries are rewritten in order 0..3,0..3, and full is never falsely asserted.
- Isolate with 3 outstanding beats: assert isolate_i with valid high -> that beat is not accepted and state=DRAIN. Step async_rptr_i to gray(3)=2 -> isolated_o=1 exactly 3 edges after the change (2 for sync, 1 for the state update). Deassert isolate_i -> isolated_o=0 and src_ready_o=1 on the next cycle.
- Isolate abort: deassert isolate_i while in DRAIN, in the same cycle empty_far becomes 1 -> state=RUN and isolated_o never pulses.
